// File: rtl/alu_mul_seq.sv
// Sequential 32x32->64 unsigned shift-add multiplier driving the shared ALU.
// Optional MUL_EARLY_EXIT_EN stops once the unconsumed multiplier bits are all zero.
module alu_mul_seq #(
    parameter logic [3:0] ALU_ADD_CODE  = 4'b0010,
    parameter logic [3:0] ALU_IDLE_CODE = 4'b0000,
    parameter int         ITER          = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] mcand_i,
    input  logic [31:0] mplier_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] prod_hi_o,
    output logic [31:0] prod_lo_o,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [3:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] mcand, acc, lo;
    logic [31:0] acc_nxt, lo_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        carry;
    logic        last;
    logic [63:0] prod_full;

`ifdef MUL_EARLY_EXIT_EN
    logic [31:0] rem, rem_nxt;
    logic [6:0]  shamt;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        alu_ctrl_o = ALU_IDLE_CODE;
        alu_src1_o = '0;
        alu_src2_o = '0;
        carry      = 1'b0;
        acc_nxt    = acc;
        lo_nxt     = lo;
        cnt_nxt    = cnt;
        last       = 1'b0;
`ifdef MUL_EARLY_EXIT_EN
        rem_nxt    = rem;
`endif
        unique case (state)
            IDLE: begin
                if (start_i) state_nxt = RUN;
            end
            RUN: begin
                busy_o     = 1'b1;
                alu_ctrl_o = ALU_ADD_CODE;
                alu_src1_o = acc;
                alu_src2_o = lo[0] ? mcand : 32'd0;
                // ALU has no carry-out; a wrapped sum is smaller than acc
                carry      = (alu_result_i < acc);
                {acc_nxt, lo_nxt} = {carry, alu_result_i, lo[31:1]};
                cnt_nxt    = cnt + 6'd1;
                last       = (cnt == 6'(ITER - 1));
`ifdef MUL_EARLY_EXIT_EN
                rem_nxt    = rem >> 1;
                last       = last || (rem_nxt == 32'd0);
`endif
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MUL_EARLY_EXIT_EN
    // Unconsumed low bits are zero, so right-aligning restores the full product
    assign shamt     = 7'(ITER) - 7'(cnt_nxt);
    assign prod_full = {acc_nxt, lo_nxt} >> shamt;
`else
    assign prod_full = {acc_nxt, lo_nxt};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand     <= '0;
            acc       <= '0;
            lo        <= '0;
            cnt       <= '0;
            prod_hi_o <= '0;
            prod_lo_o <= '0;
        end else begin
            if (state == IDLE && start_i) begin
                mcand <= mcand_i;
                lo    <= mplier_i;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                acc <= acc_nxt;
                lo  <= lo_nxt;
                cnt <= cnt_nxt;
            end
            if (state == RUN && last) begin
                prod_hi_o <= prod_full[63:32];
                prod_lo_o <= prod_full[31:0];
            end
        end
    end

`ifdef MUL_EARLY_EXIT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem <= '0;
        end else if (state == IDLE && start_i) begin
            rem <= mplier_i;
        end else if (state == RUN) begin
            rem <= rem_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized self-checking bench for alu_mul_seq with an arithmetic reference
// model and a behavioural stand-in for the shared ALU.
module tb_alu_mul_seq;

    localparam logic [3:0] ADD_C  = 4'b0010;
    localparam logic [3:0] IDLE_C = 4'b0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] mcand = '0;
    logic [31:0] mplier = '0;
    logic        busy, done;
    logic [31:0] prod_hi, prod_lo;
    logic [31:0] src1, src2, alu_res;
    logic [3:0]  ctrl;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] prev_prod = '0;

    always #5 clk = ~clk;

    // Shared ALU: ADD or AND
    assign alu_res = (ctrl == ADD_C) ? src1 + src2 : src1 & src2;

    alu_mul_seq dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .mcand_i      (mcand),
        .mplier_i     (mplier),
        .busy_o       (busy),
        .done_o       (done),
        .prod_hi_o    (prod_hi),
        .prod_lo_o    (prod_lo),
        .alu_src1_o   (src1),
        .alu_src2_o   (src2),
        .alu_ctrl_o   (ctrl),
        .alu_result_i (alu_res)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Iterations before done: full width, or up to the top set bit
    function automatic int n_iter(input logic [31:0] b);
        int n;
        n = 32;
`ifdef MUL_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < 32; i++)
            if (b[i]) n = i + 1;
`endif
        return n;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int poke_at);
        logic [63:0] exp;
        int n, done_at, done_cnt, busy_cnt;
        exp      = 64'(a) * 64'(b);
        n        = n_iter(b);
        done_at  = -1;
        done_cnt = 0;
        busy_cnt = 0;
        chk("idle_ctrl", 64'(ctrl), 64'(IDLE_C));
        chk("idle_src", {src1, src2}, 64'd0);
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
        for (int k = 0; k <= n + 3; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k < n) begin
                chk("run_ctrl", 64'(ctrl), 64'(ADD_C));
                chk("run_src2", 64'(src2), b[k] ? 64'(a) : 64'd0);
            end
            if (k == 0) chk("prod_hold_busy", {prod_hi, prod_lo}, prev_prod);
            if (k == n) chk("prod_at_done", {prod_hi, prod_lo}, exp);
            if (k == poke_at) begin
                start  = 1'b1;
                mcand  = 32'd7;
                mplier = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("done_at", 64'(done_at), 64'(n));
        chk("done_cnt", 64'(done_cnt), 64'd1);
        chk("busy_cnt", 64'(busy_cnt), 64'(n));
        chk("prod_after", {prod_hi, prod_lo}, exp);
        chk("after_ctrl", 64'(ctrl), 64'(IDLE_C));
        prev_prod = exp;
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          np;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
        chk("rst_ctrl", 64'(ctrl), 64'(IDLE_C));
        chk("rst_src", {src1, src2}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd3, 32'd5, -1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        chk("max_prod", {prod_hi, prod_lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h1234, 32'h10, 10);
        run_op(32'd7, 32'd2, -1);
        run_op(32'd7, 32'd0, -1);
        run_op(32'd0, 32'hDEAD_BEEF, -1);
        run_op(32'hA5A5_1234, 32'h5, n_iter(32'h5));

        // Asynchronous abort mid-operation
        @(negedge clk);
        start  = 1'b1;
        mcand  = 32'd9;
        mplier = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_prod", {prod_hi, prod_lo}, 64'd0);
        chk("abort_ctrl", 64'(ctrl), 64'(IDLE_C));
        chk("abort_src", {src1, src2}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_prod = '0;
        run_op(32'd2, 32'd3, -1);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            np = n_iter(rb);
            run_op(ra, rb, int'($urandom_range(0, np)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned 32x32->64 multiplier controller.
- It has no adder of its own. It borrows the shared 32-bit ALU and drives that ALU's src1/src2/ctrl each cycle to perform shift-add multiplication.
- Sits beside the ALU in the execute stage and is invoked for MULT-class instructions; the CPU stalls on busy_o.

Parameters:
- ALU_ADD_CODE, 4'b0010, ALU ctrl code driven during iterations (ADD).
- ALU_IDLE_CODE, 4'b0000, ALU ctrl code driven when not iterating (AND).
- ITER, 32, number of shift-add iterations; fixed to the ALU data width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  request; accepted only in IDLE.
- mcand_i  input  32  multiplicand; sampled on the accepting edge.
- mplier_i  input  32  multiplier; sampled on the accepting edge.
- busy_o  output  1  high while iterating.
- done_o  output  1  one-cycle pulse when the product is valid.
- prod_hi_o  output  32  product bits [63:32], registered.
- prod_lo_o  output  32  product bits [31:0], registered.
- alu_src1_o  output  32  to ALU src1_i.
- alu_src2_o  output  32  to ALU src2_i.
- alu_ctrl_o  output  4  to ALU ctrl_i.
- alu_result_i  input  32  from ALU result_o (combinational path through the ALU).

Behaviour:
- Reset:
  - Asynchronous, active-high, clears every register immediately, including mid-operation (the operation is aborted and its result discarded).
  - State returns to IDLE.
  - busy_o=0, done_o=0, prod_hi_o=prod_lo_o=0.
  - alu_ctrl_o=ALU_IDLE_CODE, alu_src1_o=alu_src2_o=0.
- States: IDLE, RUN, DONE.
- Internal registers: mcand (32), acc (32, running high half), lo (32, multiplier shifting into product low half), cnt (6).
- IDLE:
  - start_i=1 at edge E0: mcand<=mcand_i, lo<=mplier_i, acc<=0, cnt<=0; go to RUN.
  - start_i=0: stay in IDLE.
- RUN, one iteration per cycle:
  - Drive alu_ctrl_o=ALU_ADD_CODE, alu_src1_o=acc, alu_src2_o = lo[0] ? mcand : 0.
  - Carry-out c = (alu_result_i < acc), unsigned compare done locally because the ALU has no carry.
  - Next edge: {acc, lo} <= {c, alu_result_i, lo[31:1]}, cnt<=cnt+1.
  - When cnt==ITER-1: the iteration completes, then go to DONE.
  - With start at E0, the last iteration ends at edge E32.
- Entering DONE: prod_hi_o<=next acc, prod_lo_o<=next lo, done_o<=1. done_o is high for exactly one cycle (E32..E33).
- DONE: next edge unconditionally returns to IDLE. start_i in the DONE cycle is ignored.
- busy_o: 1 in RUN only (E0..E32).
- prod_*_o hold their value until the next DONE. They do not change on start or while busy.
- start_i while busy or in DONE: ignored; operands are not resampled.
- ALU outputs in IDLE/DONE: ALU_IDLE_CODE with zero operands, so another user may mux onto the ALU.
- Boundary cases:
  - Operand 0: full ITER iterations, product 0.
  - Max operands: the carry path must produce 0xFFFFFFFE_00000001.
- Latency: 33 cycles from the accepting edge to the end of the done_o pulse. The result is visible from edge E32.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - Adds a register rem = multiplier bits not yet consumed, loaded with mplier_i and shifted right each iteration.
  - After any iteration where the next rem==0, go to DONE immediately.
  - The product is written as {acc, lo} >> (ITER - cnt_next), zero-filled, so the result equals the full-run value.
  - Minimum one iteration: mplier 0 gives done at E1.
- Undefined:
  - rem logic is absent.
  - Always exactly ITER iterations, done at E32 regardless of operands.

Test Plan:
- Basic product: reset, start with mcand=3, mplier=5 -> busy_o high E0..E32; done pulse at E32; prod_hi_o=0, prod_lo_o=15.
- Carry path: mcand=mplier=0xFFFFFFFF -> prod_hi_o=0xFFFFFFFE, prod_lo_o=0x00000001.
- Start ignored while busy: start 0x1234*0x10; pulse start with 7*7 at E10 -> one done only, at E32; product 0x12340; no second done.
- Reset mid-operation: start 9*9, assert rst_i asynchronously mid-cycle at E15 -> all outputs 0 at once; after release, start 2*3 -> done at E32, product 6.
- Early exit, macro defined: mcand=7, mplier=2 -> done at E2, product 14. With mplier=0 -> done at E1, product 0. Macro undefined -> both cases done at E32 with the same products.
- ALU interface: in IDLE, alu_ctrl_o=4'b0000 and srcs 0. In RUN, ctrl=4'b0010 each cycle, and alu_src2_o equals mcand exactly on cycles where lo[0]=1 (check with mplier=0x5).
